// File: rtl/inst_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_pkg
//  Description : Shared constants and FSM state encoding for the instruction
//                memory block (fetch width, NOP encoding, enable levels).
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_mem_pkg;

  localparam int          c_PC_LENGTH  = 32;
  localparam int          c_INST_WIDTH = 32;
  localparam logic [31:0] c_NOP_INST   = 32'h0000_0000;
  localparam logic        c_ENABLE     = 1'b1;
  localparam logic        c_DISABLE    = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

endpackage : inst_mem_pkg
`default_nettype wire

// File: rtl/inst_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_array
//  Description : DEPTH x WIDTH storage, one synchronous write port and one
//                synchronous read port. Contents are not reset.
//  Ports       : clk            - clock
//                we/waddr/wdata - write port (written on rising edge)
//                re/raddr       - read port (rdata updated on rising edge)
//                rdata          - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule : inst_mem_array
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem
//  Description : Loadable instruction ROM. A program is streamed in through
//                the load handshake (IDLE -> LOAD -> RUN); in RUN the IF
//                stage fetches words with a one-cycle latency.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                rom_ce, pc         - fetch enable and byte address
//                inst, inst_valid   - fetched word and its qualifier
//                addr_err           - last fetch misaligned / beyond program
//                load_start/done    - one-cycle pulses framing a load
//                load_valid/data    - load word stream
//                load_ready         - high while in LOAD
//                state_run          - high while in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int PC_LENGTH = c_PC_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rom_ce,
  input  logic [PC_LENGTH-1:0]    pc,
  output logic [c_INST_WIDTH-1:0] inst,
  output logic                    inst_valid,
  output logic                    addr_err,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic [c_INST_WIDTH-1:0] load_data,
  output logic                    load_ready,
  input  logic                    load_done,
  output logic                    state_run
);

  localparam int c_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int c_NW = $clog2(MEM_DEPTH + 1);
  localparam int c_IW = PC_LENGTH - 2;
  localparam int c_CW = (c_IW > c_NW) ? c_IW : c_NW;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_AW-1:0]           r_wptr;
  logic [c_NW-1:0]           r_nwords;
  logic                      w_wr_en;
  logic                      w_last;
  logic [c_IW-1:0]           w_index;
  logic                      w_fetch;
  logic                      w_misalign;
  logic                      w_oob;
  logic                      w_hit;
  logic                      r_hit;
  logic                      r_addr_err;
  logic [c_INST_WIDTH-1:0]   w_rd_data;

  // A load_start in the same cycle restarts the load, so its data is dropped.
  assign w_wr_en = load_valid && (r_state == S_LOAD) && !load_start && !rst;
  assign w_last  = (r_wptr == c_AW'(MEM_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load_start) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_LOAD:  if (load_done || (w_wr_en && w_last)) w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      r_wptr   <= '0;
      r_nwords <= '0;
    end else if (w_wr_en) begin
      r_wptr   <= r_wptr + c_AW'(1);
      r_nwords <= r_nwords + c_NW'(1);
    end
  end

  // Fetch qualification uses the pre-edge state, so the cycle that leaves
  // LOAD for RUN (or RUN for LOAD) never returns a real instruction.
  assign w_index    = pc[PC_LENGTH-1:2];
  assign w_fetch    = (r_state == S_RUN) && (rom_ce == c_ENABLE) && !load_start;
  assign w_misalign = (pc[1:0] != 2'b00);
  assign w_oob      = (c_CW'(w_index) >= c_CW'(r_nwords));
  assign w_hit      = w_fetch && !w_misalign && !w_oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit      <= c_DISABLE;
      r_addr_err <= c_DISABLE;
    end else begin
      r_hit      <= w_hit;
      r_addr_err <= w_fetch && (w_misalign || w_oob);
    end
  end

  inst_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (c_AW),
    .WIDTH (c_INST_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (r_wptr),
    .wdata (load_data),
    .re    (w_hit),
    .raddr (c_AW'(w_index)),
    .rdata (w_rd_data)
  );

  // Array read data is registered; it is only exposed when the fetch hit.
  assign inst       = r_hit ? w_rd_data : c_NOP_INST;
  assign inst_valid = r_hit;
  assign addr_err   = r_addr_err;
  assign load_ready = (r_state == S_LOAD);
  assign state_run  = (r_state == S_RUN);

endmodule : inst_mem
`default_nettype wire

// File: doc/inst_mem.md
INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 The block SHALL have reset rst, synchronous, active-high, and clock clk.
REQ-002 Parameter MEM_DEPTH, default 1024, number of 32-bit instruction words.
REQ-003 Parameter PC_LENGTH, default 32, width of the fetch address.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rom_ce  input  1  fetch enable from the IF stage; active-high.
REQ-007 pc  input  PC_LENGTH  byte address of the instruction to fetch.
REQ-008 inst  output  32  registered fetched instruction.
REQ-009 inst_valid  output  1  inst holds a real instruction fetched the previous cycle.
REQ-010 addr_err  output  1  previous fetch was misaligned or outside the loaded program.
REQ-011 load_start  input  1  one-cycle pulse; begins program load.
REQ-012 load_valid  input  1  load_data is presented.
REQ-013 load_data  input  32  instruction word to write.
REQ-014 load_ready  output  1  block accepts load_data this cycle.
REQ-015 load_done  input  1  one-cycle pulse; ends program load.
REQ-016 state_run  output  1  block is in RUN and serving fetches.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-018 In any state, load_start SHALL move to LOAD, clear write pointer wptr and clear loaded-word count nwords.
REQ-019 load_ready SHALL be 1 in LOAD only; when load_valid=1 and load_ready=1, mem[wptr] SHALL be written with load_data, and wptr and nwords SHALL each increment by 1.
REQ-020 In LOAD, load_done, or a write at wptr=MEM_DEPTH-1, SHALL move to RUN next cycle; a write in the same cycle as load_done SHALL be performed first.
REQ-021 load_valid outside LOAD SHALL be ignored; load_done outside LOAD SHALL be ignored; load_start and load_done together SHALL give LOAD (load_start wins).
REQ-022 Fetch latency SHALL be exactly 1 cycle: pc sampled at edge N, inst/inst_valid/addr_err valid after edge N.
REQ-023 In RUN with rom_ce=1: word index = pc[PC_LENGTH-1:2]; if pc[1:0]!=0 or index>=nwords then inst=0x00000000 (NOP), inst_valid=0, addr_err=1; else inst=mem[index], inst_valid=1, addr_err=0.
REQ-024 With rom_ce=0, or in IDLE or LOAD, inst SHALL be 0x00000000, inst_valid=0 and addr_err=0 after the edge.
REQ-025 A fetch in the cycle that enters RUN from LOAD SHALL be treated as outside RUN (NOP, inst_valid=0).
REQ-026 A fetch from an index written in the same cycle SHALL not occur (reads only in RUN, writes only in LOAD).
REQ-027 state_run SHALL be 1 exactly when the FSM is in RUN.

Reset
REQ-028 On rst=1 at an edge: state=IDLE, wptr=0, nwords=0, inst=0, inst_valid=0, addr_err=0, load_ready=0; the memory array SHALL not be cleared.
REQ-029 rst SHALL override load_start, load_valid and load_done in the same cycle; reset during LOAD SHALL abandon the load.

Structure
REQ-030 Shared package/header SHALL hold PC_LENGTH, INST_WIDTH=32, NOP_INST=32'h0, ENABLE/DISABLE and the FSM state encodings.
REQ-031 Storage SHALL be a sub-module inst_mem_array: 1 synchronous write port, 1 synchronous read port, MEM_DEPTH x 32, no reset.
REQ-032 The FSM, pointers, address check and output registers SHALL live in inst_mem.

Verification
REQ-033 Reset, then rom_ce=1, pc=0 -> inst=0, inst_valid=0, addr_err=0, state_run=0.
REQ-034 load_start; write 0x20010005, 0x20020003, 0x00221820; load_done; then pc=0,4,8 on consecutive cycles -> those three words, inst_valid=1, one cycle later each.
REQ-035 After REQ-034 load, pc=0x2 -> addr_err=1, inst=0; pc=0xC -> addr_err=1, inst_valid=0.
REQ-036 load_valid held 1 for MEM_DEPTH cycles in LOAD without load_done -> automatic RUN after word 1023; pc=0xFFC returns last word.
REQ-037 rst asserted mid-load after 2 words -> IDLE, load_ready=0, fetch pc=0 returns NOP, inst_valid=0.
REQ-038 rom_ce=0 in RUN -> inst=0, inst_valid=0 next cycle; load_start in RUN -> load_ready=1 next cycle, fetches return NOP.
